reset_sequencer: RTL and testbench

Parametrised power-on and runtime reset sequencer for the chip top level, clocked from `CPU_CLK`. After the external reset is released and the clocks report lock, it releases `NDOM` downstream reset domains in a fixed staggered order, for example memory controllers first, then LSAB/peripherals, then CPU. It adds a software reset request, a watchdog and a sticky reset-cause register. Its outputs drive the per-domain active-low resets of the core and peripherals.

---
 rtl/reset_sequencer.sv | 157 +++++++++++++++
 tb/tb_reset_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Chip-level reset sequencer: staggered release of NDOM active-low reset domains
// after clock lock, with software reset, watchdog and a sticky reset-cause record.
module reset_sequencer #(
  parameter int NDOM       = 4,
  parameter int CNT_W      = 20,
  parameter int BASE_DLY   = 16'hFFFF,
  parameter int STAGE_GAP  = 1024,
  parameter int ASSERT_CYC = 64,
  parameter int WDT_W      = 24,
  parameter int WDT_LIMIT  = 24'hFF_FFFF
) (
  input  logic            CPU_CLK,
  input  logic            RST,
  input  logic            lock_ok,
  input  logic            sw_rst_req,
  input  logic            wdt_en,
  input  logic            wdt_kick,
  output logic [NDOM-1:0] rst_out_n,
  output logic            all_released,
  output logic [1:0]      rst_cause,
  output logic [1:0]      seq_state
);

  typedef enum logic [1:0] {
    ST_HOLD   = 2'b00,
    ST_COUNT  = 2'b01,
    ST_RUN    = 2'b10,
    ST_ASSERT = 2'b11
  } state_e;

  localparam longint unsigned LAST_THR_L = 64'(BASE_DLY) + 64'(NDOM - 1) * 64'(STAGE_GAP);
  localparam logic [CNT_W-1:0] LAST_THR  = CNT_W'(LAST_THR_L);
  localparam logic [WDT_W-1:0] WDT_MAX   = WDT_W'(WDT_LIMIT);
  localparam int               HC_W      = (ASSERT_CYC > 1) ? $clog2(ASSERT_CYC) : 1;
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(ASSERT_CYC - 1);

  if (LAST_THR_L >= (64'd1 << CNT_W)) begin : g_thr_chk
    $error("reset_sequencer: last release threshold does not fit in CNT_W bits");
  end
  if (ASSERT_CYC < 1) begin : g_asrt_chk
    $error("reset_sequencer: ASSERT_CYC must be at least 1");
  end

  state_e           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WDT_W-1:0] wdt_cnt_r;
  logic [HC_W-1:0]  hold_r;
  logic             sw_evt_s;
  logic             lock_evt_s;
  logic             wdt_exp_s;
  logic [1:0]       cause_s;

  function automatic logic [CNT_W-1:0] release_thr(input int k);
    return CNT_W'(BASE_DLY + k * STAGE_GAP);
  endfunction

  // Runtime reset triggers, resolved by priority: software > lock loss > watchdog.
  always_comb begin
    sw_evt_s   = 1'b0;
    lock_evt_s = 1'b0;
    wdt_exp_s  = 1'b0;
    cause_s    = rst_cause;
    if (state_r != ST_ASSERT) begin
      sw_evt_s = sw_rst_req;
    end else begin
      sw_evt_s = 1'b0;
    end
    if ((state_r == ST_COUNT) || (state_r == ST_RUN)) begin
      lock_evt_s = ~lock_ok;
    end else begin
      lock_evt_s = 1'b0;
    end
    if ((state_r == ST_RUN) && wdt_en && !wdt_kick && (wdt_cnt_r == WDT_MAX)) begin
      wdt_exp_s = 1'b1;
    end else begin
      wdt_exp_s = 1'b0;
    end
    if (sw_evt_s) begin
      cause_s = 2'b01;
    end else if (lock_evt_s) begin
      cause_s = 2'b00;
    end else if (wdt_exp_s) begin
      cause_s = 2'b10;
    end else begin
      cause_s = rst_cause;
    end
  end

  // Sequencer FSM with registered domain resets, status and cause.
  always_ff @(posedge CPU_CLK or negedge RST) begin
    if (!RST) begin
      state_r      <= ST_HOLD;
      cnt_r        <= '0;
      wdt_cnt_r    <= '0;
      hold_r       <= '0;
      rst_out_n    <= '0;
      all_released <= 1'b0;
      rst_cause    <= 2'b00;
    end else if (sw_evt_s || lock_evt_s || wdt_exp_s) begin
      state_r      <= ST_ASSERT;
      cnt_r        <= '0;
      wdt_cnt_r    <= '0;
      hold_r       <= '0;
      rst_out_n    <= '0;
      all_released <= 1'b0;
      rst_cause    <= cause_s;
    end else begin
      case (state_r)
        ST_HOLD: begin
          rst_out_n    <= '0;
          all_released <= 1'b0;
          if (lock_ok) begin
            state_r <= ST_COUNT;
            cnt_r   <= '0;
          end
        end
        ST_COUNT: begin
          for (int k = 0; k < NDOM; k++) begin
            if (cnt_r == release_thr(k)) begin
              rst_out_n[k] <= 1'b1;
            end
          end
          // Counter parks on the last threshold so it can never wrap.
          if (cnt_r == LAST_THR) begin
            state_r      <= ST_RUN;
            all_released <= 1'b1;
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_RUN: begin
          if (!wdt_en || wdt_kick) begin
            wdt_cnt_r <= '0;
          end else begin
            wdt_cnt_r <= wdt_cnt_r + {{(WDT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_ASSERT: begin
          rst_out_n    <= '0;
          all_released <= 1'b0;
          if (hold_r == HOLD_LAST) begin
            state_r <= ST_HOLD;
            hold_r  <= '0;
          end else begin
            hold_r <= hold_r + {{(HC_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= ST_HOLD;
        end
      endcase
    end
  end

  assign seq_state = state_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a spec-level cycle model feeds a scoreboard queue,
// plus directed timing checks taken from the reset sequencing scenarios.
module tb_reset_sequencer;

  localparam int NDOM       = 4;
  localparam int CNT_W      = 20;
  localparam int BASE_DLY   = 16;
  localparam int STAGE_GAP  = 8;
  localparam int ASSERT_CYC = 4;
  localparam int WDT_W      = 24;
  localparam int WDT_LIMIT  = 100;

  logic            CPU_CLK = 1'b0;
  logic            RST;
  logic            lock_ok;
  logic            sw_rst_req;
  logic            wdt_en;
  logic            wdt_kick;
  logic [NDOM-1:0] rst_out_n;
  logic            all_released;
  logic [1:0]      rst_cause;
  logic [1:0]      seq_state;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  logic [1:0]      m_state;
  logic [1:0]      m_cause;
  logic [NDOM-1:0] m_rel;
  logic            m_all;
  int              m_cnt;
  int              m_wdt;
  int              m_hold;

  always #5 CPU_CLK = ~CPU_CLK;

  reset_sequencer #(
    .NDOM(NDOM), .CNT_W(CNT_W), .BASE_DLY(BASE_DLY), .STAGE_GAP(STAGE_GAP),
    .ASSERT_CYC(ASSERT_CYC), .WDT_W(WDT_W), .WDT_LIMIT(WDT_LIMIT)
  ) dut (
    .CPU_CLK(CPU_CLK), .RST(RST), .lock_ok(lock_ok), .sw_rst_req(sw_rst_req),
    .wdt_en(wdt_en), .wdt_kick(wdt_kick), .rst_out_n(rst_out_n),
    .all_released(all_released), .rst_cause(rst_cause), .seq_state(seq_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] obs();
    return {seq_state, rst_cause, all_released, rst_out_n};
  endfunction

  function automatic logic [8:0] mexp();
    return {m_state, m_cause, m_all, m_rel};
  endfunction

  task automatic model_reset();
    m_state = 2'b00; m_cause = 2'b00; m_rel = '0; m_all = 1'b0;
    m_cnt = 0; m_wdt = 0; m_hold = 0;
  endtask

  // Spec model of one rising edge, using the inputs currently driven.
  task automatic model_edge();
    logic sw;
    logic ll;
    logic wx;
    sw = sw_rst_req && (m_state != 2'b11);
    ll = !lock_ok && ((m_state == 2'b01) || (m_state == 2'b10));
    wx = (m_state == 2'b10) && wdt_en && !wdt_kick && (m_wdt == WDT_LIMIT);
    if (sw || ll || wx) begin
      m_cause = sw ? 2'b01 : (ll ? 2'b00 : 2'b10);
      m_state = 2'b11; m_hold = 0; m_cnt = 0; m_wdt = 0; m_rel = '0; m_all = 1'b0;
    end else begin
      case (m_state)
        2'b00: if (lock_ok) begin m_state = 2'b01; m_cnt = 0; end
        2'b01: begin
          for (int k = 0; k < NDOM; k++)
            if (m_cnt >= BASE_DLY + k * STAGE_GAP) m_rel[k] = 1'b1;
          if (m_cnt == BASE_DLY + (NDOM - 1) * STAGE_GAP) begin
            m_state = 2'b10; m_all = 1'b1;
          end else begin
            m_cnt++;
          end
        end
        2'b10: m_wdt = (!wdt_en || wdt_kick) ? 0 : m_wdt + 1;
        default: begin
          m_hold++;
          if (m_hold == ASSERT_CYC) m_state = 2'b00;
        end
      endcase
    end
  endtask

  // One clock: push the model's prediction, let the DUT clock, pop and compare.
  task automatic step();
    model_edge();
    exp_q.push_back(mexp());
    @(posedge CPU_CLK);
    #1;
    check("cycle", 32'(obs()), 32'(exp_q.pop_front()));
    sw_rst_req = 1'b0;
    wdt_kick   = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic async_reset();
    #3;
    RST = 1'b0;
    model_reset();
    #1;
    check("async_rst_outputs", 32'(obs()), 32'd0);
    check("async_rst_cause", 32'(rst_cause), 32'd0);
    @(posedge CPU_CLK);
    #1;
    RST = 1'b1;
  endtask

  initial begin
    RST = 1'b0; lock_ok = 1'b0; sw_rst_req = 1'b0; wdt_en = 1'b0; wdt_kick = 1'b0;
    model_reset();
    #12;
    check("reset_state", 32'(obs()), 32'd0);
    @(posedge CPU_CLK);
    #1;
    RST = 1'b1;

    // Power-on: lock rises on the fifth clock, domains release at 8-cycle spacing.
    steps(4);
    lock_ok = 1'b1;
    step();
    check("hold_to_count", 32'(seq_state), 32'd1);
    for (int j = 1; j <= 41; j++) begin
      step();
      if (j == 16) check("pwr_dom0_early", 32'(rst_out_n), 32'h0);
      if (j == 17) check("pwr_dom0", 32'(rst_out_n), 32'h1);
      if (j == 25) check("pwr_dom1", 32'(rst_out_n), 32'h3);
      if (j == 33) check("pwr_dom2", 32'(rst_out_n), 32'h7);
      if (j == 40) check("pwr_all_early", 32'(all_released), 32'd0);
      if (j == 41) check("pwr_dom3", 32'({seq_state, all_released, rst_out_n}), 32'h5F);
    end
    check("pwr_cause", 32'(rst_cause), 32'd0);

    // Software reset in RUN: 4 ASSERT cycles, HOLD, full sequence again.
    sw_rst_req = 1'b1;
    step();
    check("sw_assert", 32'({seq_state, rst_out_n}), 32'h30);
    for (int j = 1; j <= 46; j++) begin
      step();
      if (j == 3)  check("sw_still_assert", 32'(seq_state), 32'd3);
      if (j == 4)  check("sw_hold", 32'(seq_state), 32'd0);
      if (j == 45) check("sw_rel_early", 32'(all_released), 32'd0);
      if (j == 46) check("sw_rel", 32'(all_released), 32'd1);
    end
    check("sw_cause", 32'(rst_cause), 32'd1);

    // Watchdog without kicks expires after 101 cycles.
    wdt_en = 1'b1;
    for (int j = 1; j <= 101; j++) begin
      step();
      if (j == 100) check("wdt_pre_expiry", 32'(seq_state), 32'd2);
      if (j == 101) check("wdt_expiry", 32'({seq_state, rst_cause}), 32'hE);
    end
    wdt_en = 1'b0;
    steps(46);
    check("wdt_recovered", 32'(seq_state), 32'd2);

    // Kicking every 50 cycles keeps the system running.
    wdt_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      wdt_kick = ((i % 50) == 49);
      step();
    end
    check("wdt_kicked_run", 32'({seq_state, all_released}), 32'h5);

    // Software request in the expiry cycle wins over the watchdog.
    steps(100);
    sw_rst_req = 1'b1;
    step();
    check("coincide_sw_cause", 32'({seq_state, rst_cause}), 32'hD);
    wdt_en = 1'b0;
    steps(46);

    // A kick in the expiry cycle prevents the reset.
    wdt_en = 1'b1;
    steps(100);
    wdt_kick = 1'b1;
    step();
    check("kick_at_expiry", 32'(seq_state), 32'd2);
    steps(5);
    check("kick_still_run", 32'(seq_state), 32'd2);
    wdt_en = 1'b0;
    step();

    // Lock loss after domain 1 is released.
    sw_rst_req = 1'b1;
    step();
    steps(30);
    check("ll_dom1", 32'({seq_state, rst_out_n}), 32'h13);
    lock_ok = 1'b0;
    step();
    check("ll_assert", 32'({seq_state, rst_cause, rst_out_n}), 32'hC0);
    steps(4);
    check("ll_hold", 32'(seq_state), 32'd0);
    steps(20);
    check("ll_stay_hold", 32'({seq_state, rst_out_n}), 32'h00);
    lock_ok = 1'b1;
    for (int j = 1; j <= 42; j++) begin
      step();
      if (j == 41) check("ll_rel_early", 32'(all_released), 32'd0);
      if (j == 42) check("ll_rel", 32'(all_released), 32'd1);
    end

    // Asynchronous reset mid-ASSERT and mid-RUN.
    sw_rst_req = 1'b1;
    step();
    step();
    check("pre_async_assert", 32'({seq_state, rst_cause}), 32'hD);
    async_reset();
    steps(42);
    check("async_recover", 32'(seq_state), 32'd2);
    sw_rst_req = 1'b1;
    step();
    steps(46);
    check("pre_async_run", 32'({seq_state, rst_cause}), 32'h9);
    async_reset();
    steps(3);
    check("post_async_count", 32'(seq_state), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
